// File: rtl/scoreboard_pkg.sv
// Shared types for the scoreboard display path: entry word layout, leaderboard
// entry struct and insertion FSM states.
package scoreboard_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned ID_LSB        = 16;
    localparam int unsigned SCORE_LSB     = 0;
    localparam int unsigned ENTRY_ID_W    = WORD_W - ID_LSB;
    localparam int unsigned ENTRY_SCORE_W = ID_LSB - SCORE_LSB;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StShift,
        StWrite
    } ins_state_e;

    typedef struct packed {
        logic                     valid;
        logic [ENTRY_ID_W-1:0]    id;
        logic [ENTRY_SCORE_W-1:0] score;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '0;

    function automatic entry_t word_to_entry(input logic [WORD_W-1:0] word);
        entry_t e;
        e.valid = 1'b1;
        e.id    = word[WORD_W-1:ID_LSB];
        e.score = word[ID_LSB-1:SCORE_LSB];
        return e;
    endfunction

endpackage

// File: rtl/scoreboard_if.sv
// Bundle of the scoreboard stream input, frame control and display outputs.
// The master side feeds entries and watches the display; the slave is the leaderboard.
interface scoreboard_if #(
    parameter int unsigned ID_W    = 16,
    parameter int unsigned SCORE_W = 16
);
    import scoreboard_pkg::*;

    logic [WORD_W-1:0]  scoreboard_output;
    logic               scoreboard_parity;
    logic               frame_clear;
    logic [3:0]         disp_rank;
    logic [ID_W-1:0]    disp_userid;
    logic [SCORE_W-1:0] disp_score;
    logic               disp_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output scoreboard_output, scoreboard_parity, frame_clear,
        input  disp_rank, disp_userid, disp_score, disp_valid, busy, overrun
    );

    modport slave (
        input  scoreboard_output, scoreboard_parity, frame_clear,
        output disp_rank, disp_userid, disp_score, disp_valid, busy, overrun
    );

endinterface

// File: rtl/scoreboard_toggle_rx.sv
// Parity-toggle receiver: detects new entry words, drops empty rows, buffers one
// entry while the insertion FSM is busy and flags entries lost to overflow.
module scoreboard_toggle_rx
    import scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_i,
    input  logic              parity_i,
    input  logic              frame_clear_i,
    output logic              out_valid_o,
    output entry_t            out_entry_o,
    input  logic              out_ready_i,
    output logic              overrun_o
);

    logic   last_parity_q;
    entry_t hold_q, hold_d;
    logic   overrun_q, overrun_d;
    entry_t new_entry;
    logic   new_ok;
    logic   fire;

    always_comb begin
        new_entry = word_to_entry(word_i);
        new_ok    = (parity_i != last_parity_q) && (new_entry.id != '0);
    end

    // The held entry is older, so it is always offered first.
    assign out_valid_o = hold_q.valid || new_ok;
    assign out_entry_o = hold_q.valid ? hold_q : new_entry;
    assign fire        = out_valid_o && out_ready_i;
    assign overrun_o   = overrun_q;

    always_comb begin
        hold_d    = hold_q;
        overrun_d = overrun_q;
        if (frame_clear_i) begin
            // A toggle coinciding with the clear opens the new frame.
            hold_d    = new_ok ? new_entry : EMPTY_ENTRY;
            overrun_d = 1'b0;
        end else begin
            if (fire && hold_q.valid) begin
                hold_d = EMPTY_ENTRY;
            end
            if (new_ok) begin
                if (hold_q.valid && !fire) begin
                    overrun_d = 1'b1;
                end else if (hold_q.valid || !out_ready_i) begin
                    hold_d = new_entry;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_parity_q <= 1'b0;
            hold_q        <= EMPTY_ENTRY;
            overrun_q     <= 1'b0;
        end else begin
            last_parity_q <= parity_i;
            hold_q        <= hold_d;
            overrun_q     <= overrun_d;
        end
    end

endmodule

// File: rtl/scoreboard_display.sv
// Top-DEPTH leaderboard fed by the scoreboard stream, sorted by descending score,
// with a rotating rank-by-rank display output.
module scoreboard_display
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ID_W    = 16,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned DWELL   = 1024
) (
    input  logic          clk,
    input  logic          rst,
    scoreboard_if.slave   sb
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef logic [CW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(DEPTH - 1);

    ins_state_e       state_q, state_d;
    idx_t             idx_q, idx_d;
    idx_t             pos_q, pos_d;
    entry_t           new_q, new_d;
    entry_t           slots_q [DEPTH];
    entry_t           slots_d [DEPTH];

    logic             in_valid;
    logic             in_ready;
    entry_t           in_entry;
    logic             overrun;
    entry_t           scan_slot;
    logic             better;

    logic [DW-1:0]    dwell_q, dwell_d;
    idx_t             rank_q, rank_d;
    idx_t             disp_rank_q;
    entry_t           disp_q, disp_d;

    scoreboard_toggle_rx u_rx (
        .clk           (clk),
        .rst           (rst),
        .word_i        (sb.scoreboard_output),
        .parity_i      (sb.scoreboard_parity),
        .frame_clear_i (sb.frame_clear),
        .out_valid_o   (in_valid),
        .out_entry_o   (in_entry),
        .out_ready_i   (in_ready),
        .overrun_o     (overrun)
    );

    // A clearing cycle never accepts into the FSM; the receiver holds that entry.
    assign in_ready = (state_q == StIdle) && !sb.frame_clear;

    always_comb begin
        scan_slot = EMPTY_ENTRY;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (idx_q == idx_t'(k)) begin
                scan_slot = slots_q[k];
            end
        end
        // Strict compare: an equal score ranks behind the earlier arrival.
        better = !scan_slot.valid || (new_q.score > scan_slot.score);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        new_d   = new_q;
        slots_d = slots_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    new_d   = in_entry;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (better) begin
                    pos_d = idx_q;
                    if (idx_q == LAST) begin
                        state_d = StWrite;
                    end else begin
                        idx_d   = LAST;
                        state_d = StShift;
                    end
                end else if (idx_q == LAST) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StShift: begin
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    if (idx_q == idx_t'(k)) begin
                        slots_d[k] = slots_q[k-1];
                    end
                end
                if (idx_q == pos_q + 1'b1) begin
                    state_d = StWrite;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StWrite: begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (pos_q == idx_t'(k)) begin
                        slots_d[k] = new_q;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (sb.frame_clear) begin
            state_d = StIdle;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slots_d[k] = EMPTY_ENTRY;
            end
        end
    end

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        rank_d  = rank_q;
        if (dwell_q == DW'(DWELL - 1)) begin
            dwell_d = '0;
            rank_d  = (rank_q == LAST) ? '0 : rank_q + 1'b1;
        end
        disp_d = EMPTY_ENTRY;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (rank_q == idx_t'(k) && slots_q[k].valid) begin
                disp_d = slots_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            pos_q       <= '0;
            new_q       <= EMPTY_ENTRY;
            dwell_q     <= '0;
            rank_q      <= '0;
            disp_rank_q <= '0;
            disp_q      <= EMPTY_ENTRY;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                slots_q[k] <= EMPTY_ENTRY;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            new_q       <= new_d;
            dwell_q     <= dwell_d;
            rank_q      <= rank_d;
            disp_rank_q <= rank_q;
            disp_q      <= disp_d;
            slots_q     <= slots_d;
        end
    end

    assign sb.disp_rank   = 4'(disp_rank_q);
    assign sb.disp_userid = ID_W'(disp_q.id);
    assign sb.disp_score  = SCORE_W'(disp_q.score);
    assign sb.disp_valid  = disp_q.valid;
    assign sb.busy        = (state_q != StIdle);
    assign sb.overrun     = overrun;

endmodule
